// File: rtl/nios_system_sysid_pkg.sv
// rtl/nios_system_sysid_pkg.sv - shared state type, word addresses and default expected values
package nios_system_sysid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_ID = 2'd1,
        ST_RD_TS = 2'd2,
        ST_DONE  = 2'd3
    } sysid_state_t;

    localparam logic        SYSID_ADDR_ID    = 1'b0;
    localparam logic        SYSID_ADDR_TS    = 1'b1;
    localparam logic [31:0] SYSID_DEFAULT_ID = 32'd0;
    localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1456859263;

endpackage

// File: rtl/nios_system_sysid_watchdog.sv
// rtl/nios_system_sysid_watchdog.sv - counts consecutive stall cycles, flags when LIMIT is reached
module nios_system_sysid_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [15:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 16'd1;
        end
    end

    // Fires on the LIMIT-th stall cycle itself so the FSM leaves on that edge.
    assign expired = count_en && (count == 16'(LIMIT - 1));

endmodule

// File: rtl/nios_system_sysid_checker.sv
// rtl/nios_system_sysid_checker.sv - reads sysid ID/timestamp over Avalon-MM and checks them (optional SYSID_CHECK_TIMEOUT_EN)
module nios_system_sysid_checker
    import nios_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TS,
    parameter int          TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    sysid_state_t state;

`ifdef SYSID_CHECK_TIMEOUT_EN
    logic wd_clear;
    logic wd_count_en;
    logic wd_expired;

    assign wd_clear    = (state == ST_IDLE) || !avm_waitrequest;
    assign wd_count_en = avm_read && avm_waitrequest;

    nios_system_sysid_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (wd_clear),
        .count_en(wd_count_en),
        .expired (wd_expired)
    );
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            avm_address <= SYSID_ADDR_ID;
            avm_read    <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_RD_ID;
                        busy        <= 1'b1;
                        avm_address <= SYSID_ADDR_ID;
                        avm_read    <= 1'b1;
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                        pass        <= 1'b0;
                        timeout     <= 1'b0;
                    end
                end
                ST_RD_ID: begin
                    if (!avm_waitrequest) begin
                        state       <= ST_RD_TS;
                        id_value    <= avm_readdata;
                        id_ok       <= (avm_readdata == EXPECTED_ID);
                        avm_address <= SYSID_ADDR_TS;
                    end
`ifdef SYSID_CHECK_TIMEOUT_EN
                    else if (wd_expired) begin
                        state    <= ST_DONE;
                        avm_read <= 1'b0;
                        timeout  <= 1'b1;
                        done     <= 1'b1;
                    end
`endif
                end
                ST_RD_TS: begin
                    if (!avm_waitrequest) begin
                        state    <= ST_DONE;
                        ts_value <= avm_readdata;
                        ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
                        // id_ok is already settled; ts result is folded in directly.
                        pass     <= id_ok && (avm_readdata == EXPECTED_TIMESTAMP);
                        avm_read <= 1'b0;
                        done     <= 1'b1;
                    end
`ifdef SYSID_CHECK_TIMEOUT_EN
                    else if (wd_expired) begin
                        state    <= ST_DONE;
                        avm_read <= 1'b0;
                        timeout  <= 1'b1;
                        done     <= 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    avm_address <= SYSID_ADDR_ID;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
